// File: rtl/hcms_serial_rx.sv
// HCMS-29xx display-side receiver: deserialises the five display pins and recovers
// data bytes plus control words 0/1. Define HCMS_RX_FRAME_CHECK_EN to flag partial bytes at frame close.
module hcms_serial_rx #(
  parameter int SYNC_STAGES     = 2,
  parameter int FRAME_MAX_BYTES = 20
) (
  input  logic       CLK_i,
  input  logic       RESET_i,
  input  logic       SER_DATA,
  input  logic       SER_CLK,
  input  logic       REG_SEL,
  input  logic       nCE,
  input  logic       nRESET,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       RX_CMD,
  output logic [6:0] CTRL_W0,
  output logic [6:0] CTRL_W1,
  output logic       CTRL_STROBE,
  output logic [7:0] BYTE_COUNT,
  output logic       FRAME_ERR,
  output logic       BUSY
);

  localparam logic [7:0] MAX_BYTES = 8'(FRAME_MAX_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_END} state_t;

  state_t     state, state_n;
  logic [SYNC_STAGES-1:0][4:0] sync_q;
  logic       nrst_s, nce_s, rs_s, sc_s, sd_s;
  logic       sc_prev, nce_prev, nrst_prev;
  logic       sc_rise, nce_fall, nce_rise;
  logic [2:0] bit_cnt;
  logic [7:0] shifter;
  logic [7:0] pend_byte;
  logic       pending;
  logic       partial_ok;
  logic [7:0] byte_full;

  // All pins share one synchroniser chain so data stays aligned with its clock.
  // Left unreset on purpose: a frame open across RESET_i must not look like a new nCE fall.
  always_ff @(posedge CLK_i) begin
    sync_q    <= {sync_q[SYNC_STAGES-2:0], {nRESET, nCE, REG_SEL, SER_CLK, SER_DATA}};
    sc_prev   <= sc_s;
    nce_prev  <= nce_s;
    nrst_prev <= nrst_s;
  end

  assign {nrst_s, nce_s, rs_s, sc_s, sd_s} = sync_q[SYNC_STAGES-1];
  assign sc_rise   = sc_s & ~sc_prev;
  assign nce_fall  = nce_prev & ~nce_s;
  assign nce_rise  = ~nce_prev & nce_s;
  assign byte_full = {shifter[6:0], sd_s};
  assign BUSY      = (state == S_SHIFT);

`ifdef HCMS_RX_FRAME_CHECK_EN
  assign partial_ok = (bit_cnt == 3'd0);
`else
  assign partial_ok = 1'b1;
`endif

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (nce_fall) state_n = S_SHIFT;
      S_SHIFT: if (nce_rise) state_n = S_END;
      S_END:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (!nrst_s) state_n = S_IDLE;
  end

  always_ff @(posedge CLK_i) begin
    if (RESET_i) begin
      state       <= S_IDLE;
      RX_DATA     <= '0;
      RX_VALID    <= 1'b0;
      RX_CMD      <= 1'b0;
      CTRL_W0     <= '0;
      CTRL_W1     <= '0;
      CTRL_STROBE <= 1'b0;
      BYTE_COUNT  <= '0;
      FRAME_ERR   <= 1'b0;
      bit_cnt     <= '0;
      shifter     <= '0;
      pend_byte   <= '0;
      pending     <= 1'b0;
    end else begin
      state       <= state_n;
      RX_VALID    <= 1'b0;
      CTRL_STROBE <= 1'b0;
      if (!nrst_s) begin
        CTRL_W0     <= '0;
        CTRL_W1     <= '0;
        bit_cnt     <= '0;
        shifter     <= '0;
        pending     <= 1'b0;
        CTRL_STROBE <= nrst_prev;
      end else begin
        case (state)
          S_IDLE: if (nce_fall) begin
            bit_cnt    <= '0;
            BYTE_COUNT <= '0;
            FRAME_ERR  <= 1'b0;
            pending    <= 1'b0;
          end
          // A SER_CLK rise coinciding with the nCE rise is still shifted here.
          S_SHIFT: if (sc_rise) begin
            shifter <= byte_full;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (BYTE_COUNT != 8'hFF) BYTE_COUNT <= BYTE_COUNT + 8'd1;
              if (BYTE_COUNT < MAX_BYTES) begin
                RX_DATA  <= byte_full;
                RX_CMD   <= rs_s;
                RX_VALID <= 1'b1;
                if (rs_s) begin
                  pending   <= 1'b1;
                  pend_byte <= byte_full;
                end
              end else begin
                FRAME_ERR <= 1'b1;
              end
            end
          end
          S_END: begin
            if (!partial_ok) begin
              FRAME_ERR <= 1'b1;
            end else if (pending) begin
              if (pend_byte[7]) CTRL_W1 <= pend_byte[6:0];
              else              CTRL_W0 <= pend_byte[6:0];
              CTRL_STROBE <= 1'b1;
            end
            pending <= 1'b0;
            bit_cnt <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hcms_serial_rx.sv
// Randomised self-checking bench for hcms_serial_rx against a frame-level model.
module tb_hcms_serial_rx;
  localparam int SYNC = 2;
  localparam int MAXB = 20;
  localparam int HP   = 4;
`ifdef HCMS_RX_FRAME_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, sd = 1'b0, sc = 1'b0, rs = 1'b0, nce = 1'b1, nrst = 1'b1;
  logic [7:0] rx_data, byte_count;
  logic       rx_valid, rx_cmd, ctrl_strobe, frame_err, busy;
  logic [6:0] ctrl_w0, ctrl_w1;

  hcms_serial_rx #(.SYNC_STAGES(SYNC), .FRAME_MAX_BYTES(MAXB)) dut (
    .CLK_i(clk), .RESET_i(rst), .SER_DATA(sd), .SER_CLK(sc), .REG_SEL(rs), .nCE(nce),
    .nRESET(nrst), .RX_DATA(rx_data), .RX_VALID(rx_valid), .RX_CMD(rx_cmd),
    .CTRL_W0(ctrl_w0), .CTRL_W1(ctrl_w1), .CTRL_STROBE(ctrl_strobe),
    .BYTE_COUNT(byte_count), .FRAME_ERR(frame_err), .BUSY(busy));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int cyc_cnt = 0, rise_cyc = 0, valid_cyc = 0, strobes = 0, s0 = 0;
  logic [8:0] rx_q[$];
  logic [8:0] exp_q[$];
  logic [7:0] tx_q[$];
  logic [6:0] exp_w0 = '0, exp_w1 = '0;
  int  exp_cnt, exp_strobes;
  bit  exp_err;

  always @(posedge clk) cyc_cnt++;
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_q.push_back({rx_cmd, rx_data});
      valid_cyc = cyc_cnt;
    end
    if (ctrl_strobe) strobes++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp finish");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input bit b);
    sd = b; cyc(HP);
    sc = 1'b1; rise_cyc = cyc_cnt; cyc(HP);
    sc = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic open_frame(input bit r);
    rs = r; rx_q.delete(); s0 = strobes;
    nce = 1'b0; cyc(HP);
  endtask

  task automatic close_frame();
    cyc(HP); nce = 1'b1; cyc(12);
  endtask

  // Frame-level reference: first MAXB bytes are delivered, the count saturates,
  // and the last delivered control byte is committed by its D7.
  task automatic model_frame(input bit r, input int partial);
    int acc;
    logic [7:0] last;
    acc = (tx_q.size() < MAXB) ? tx_q.size() : MAXB;
    exp_q.delete();
    for (int i = 0; i < acc; i++) exp_q.push_back({r, tx_q[i]});
    exp_cnt = (tx_q.size() > 255) ? 255 : tx_q.size();
    exp_err = (tx_q.size() > MAXB) || (CHK && partial != 0);
    exp_strobes = 0;
    if (r && acc > 0 && !(CHK && partial != 0)) begin
      last = tx_q[acc-1];
      if (last[7]) exp_w1 = last[6:0];
      else         exp_w0 = last[6:0];
      exp_strobes = 1;
    end
  endtask

  task automatic run_frame(input bit r, input int partial, input logic [7:0] pb);
    open_frame(r);
    foreach (tx_q[i]) send_byte(tx_q[i]);
    for (int i = 0; i < partial; i++) send_bit(pb[7-i]);
    close_frame();
    model_frame(r, partial);
  endtask

  task automatic test_reset();
    rst = 1'b1; cyc(6); rst = 1'b0; cyc(1);
    n_tests++; if ({rx_data, rx_valid, rx_cmd} !== 10'd0) begin n_fail++; $display("FAIL reset_rx: got %h exp 0", {rx_data, rx_valid, rx_cmd}); end
    n_tests++; if ({ctrl_w0, ctrl_w1, ctrl_strobe} !== 15'd0) begin n_fail++; $display("FAIL reset_ctrl: got %h exp 0", {ctrl_w0, ctrl_w1, ctrl_strobe}); end
    n_tests++; if ({byte_count, frame_err, busy} !== 10'd0) begin n_fail++; $display("FAIL reset_status: got %h exp 0", {byte_count, frame_err, busy}); end
  endtask

  task automatic test_ctrl();
    int lat;
    bit ok;
    tx_q = '{8'h81}; run_frame(1'b1, 0, 8'h00);
    lat = valid_cyc - rise_cyc;
    ok = (rx_q.size() == exp_q.size());
    foreach (exp_q[i]) if (ok && rx_q[i] !== exp_q[i]) ok = 1'b0;
    n_tests++; if (!ok) begin n_fail++; $display("FAIL ctrl81_rx: got %0d bytes exp %0d (first %h)", rx_q.size(), exp_q.size(), exp_q[0]); end
    n_tests++; if (lat < SYNC + 1 || lat > SYNC + 2) begin n_fail++; $display("FAIL ctrl81_latency: got %0d exp %0d..%0d", lat, SYNC + 1, SYNC + 2); end
    n_tests++; if (ctrl_w1 !== exp_w1 || ctrl_w0 !== exp_w0) begin n_fail++; $display("FAIL ctrl81_words: got %h/%h exp %h/%h", ctrl_w0, ctrl_w1, exp_w0, exp_w1); end
    n_tests++; if (strobes - s0 !== exp_strobes) begin n_fail++; $display("FAIL ctrl81_strobe: got %0d exp %0d", strobes - s0, exp_strobes); end
    tx_q = '{8'h75}; run_frame(1'b1, 0, 8'h00);
    n_tests++; if (ctrl_w1 !== exp_w1 || ctrl_w0 !== exp_w0) begin n_fail++; $display("FAIL ctrl75_words: got %h/%h exp %h/%h", ctrl_w0, ctrl_w1, exp_w0, exp_w1); end
    n_tests++; if (byte_count !== 8'(exp_cnt) || busy !== 1'b0) begin n_fail++; $display("FAIL ctrl75_count: got %0d busy %b exp %0d busy 0", byte_count, busy, exp_cnt); end
  endtask

  task automatic test_overflow();
    bit ok;
    tx_q.delete();
    for (int i = 0; i < MAXB; i++) tx_q.push_back(8'(i));
    open_frame(1'b0);
    foreach (tx_q[i]) send_byte(tx_q[i]);
    cyc(10); model_frame(1'b0, 0);
    ok = (rx_q.size() == exp_q.size());
    foreach (exp_q[i]) if (ok && rx_q[i] !== exp_q[i]) ok = 1'b0;
    n_tests++; if (!ok) begin n_fail++; $display("FAIL ovf20_stream: got %0d bytes exp %0d", rx_q.size(), exp_q.size()); end
    n_tests++; if (byte_count !== 8'(exp_cnt) || frame_err !== exp_err || busy !== 1'b1) begin n_fail++; $display("FAIL ovf20_status: got cnt %0d err %b busy %b exp %0d %b 1", byte_count, frame_err, busy, exp_cnt, exp_err); end
    tx_q.push_back(8'h14); send_byte(8'h14);
    cyc(10); model_frame(1'b0, 0);
    n_tests++; if (rx_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL ovf21_valid: got %0d bytes exp %0d", rx_q.size(), exp_q.size()); end
    n_tests++; if (byte_count !== 8'(exp_cnt) || frame_err !== exp_err) begin n_fail++; $display("FAIL ovf21_status: got cnt %0d err %b exp %0d %b", byte_count, frame_err, exp_cnt, exp_err); end
    close_frame();
    n_tests++; if (strobes - s0 !== 0 || busy !== 1'b0) begin n_fail++; $display("FAIL ovf_close: got strobes %0d busy %b exp 0 0", strobes - s0, busy); end
  endtask

  task automatic test_partial();
    tx_q.delete(); run_frame(1'b1, 5, 8'hF0);
    n_tests++; if (rx_q.size() !== 0) begin n_fail++; $display("FAIL partial_valid: got %0d bytes exp 0", rx_q.size()); end
    n_tests++; if (frame_err !== exp_err) begin n_fail++; $display("FAIL partial_err: got %b exp %b", frame_err, exp_err); end
    n_tests++; if (ctrl_w1 !== exp_w1 || strobes - s0 !== exp_strobes) begin n_fail++; $display("FAIL partial_ctrl: got %h/%0d exp %h/%0d", ctrl_w1, strobes - s0, exp_w1, exp_strobes); end
  endtask

  task automatic test_nreset();
    bit ok;
    tx_q = '{8'h75}; run_frame(1'b1, 0, 8'h00);
    tx_q = '{8'h81}; run_frame(1'b1, 0, 8'h00);
    open_frame(1'b1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    nrst = 1'b0; cyc(10);
    exp_w0 = '0; exp_w1 = '0;
    send_byte(8'hA5);
    n_tests++; if (ctrl_w0 !== exp_w0 || ctrl_w1 !== exp_w1) begin n_fail++; $display("FAIL nrst_words: got %h/%h exp %h/%h", ctrl_w0, ctrl_w1, exp_w0, exp_w1); end
    n_tests++; if (strobes - s0 !== 1 || rx_q.size() !== 0 || busy !== 1'b0) begin n_fail++; $display("FAIL nrst_side: got strobes %0d bytes %0d busy %b exp 1 0 0", strobes - s0, rx_q.size(), busy); end
    nrst = 1'b1; close_frame();
    tx_q = '{8'h81}; run_frame(1'b1, 0, 8'h00);
    ok = (rx_q.size() == exp_q.size());
    foreach (exp_q[i]) if (ok && rx_q[i] !== exp_q[i]) ok = 1'b0;
    n_tests++; if (!ok || ctrl_w1 !== exp_w1 || ctrl_w0 !== exp_w0) begin n_fail++; $display("FAIL nrst_after: got %0d bytes w %h/%h exp %0d w %h/%h", rx_q.size(), ctrl_w0, ctrl_w1, exp_q.size(), exp_w0, exp_w1); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    rx_q.delete(); nce = 1'b1;
    for (int i = 0; i < 16; i++) begin
      sd = 1'($urandom); sc = 1'b1; cyc(HP); sc = 1'b0; cyc(HP);
    end
    n_tests++; if (rx_q.size() !== 0) begin n_fail++; $display("FAIL idle_clk: got %0d bytes exp 0", rx_q.size()); end
    tx_q = '{8'h9C}; run_frame(1'b1, 0, 8'h00);
    open_frame(1'b1);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    rst = 1'b1; cyc(2); rst = 1'b0; cyc(1);
    exp_w0 = '0; exp_w1 = '0;
    n_tests++; if ({rx_data, rx_valid, rx_cmd, ctrl_w0, ctrl_w1, ctrl_strobe, byte_count, frame_err, busy} !== 35'd0) begin
      n_fail++; $display("FAIL midrst_outputs: got %h exp 0", {rx_data, rx_valid, rx_cmd, ctrl_w0, ctrl_w1, ctrl_strobe, byte_count, frame_err, busy}); end
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_byte(8'h3C);
    close_frame();
    n_tests++; if (rx_q.size() !== 0 || ctrl_w0 !== 7'd0) begin n_fail++; $display("FAIL midrst_abandon: got %0d bytes w0 %h exp 0 0", rx_q.size(), ctrl_w0); end
    tx_q = '{8'($urandom), 8'($urandom)}; run_frame(1'b0, 0, 8'h00);
    ok = (rx_q.size() == exp_q.size());
    foreach (exp_q[i]) if (ok && rx_q[i] !== exp_q[i]) ok = 1'b0;
    n_tests++; if (!ok || byte_count !== 8'(exp_cnt)) begin n_fail++; $display("FAIL midrst_next: got %0d bytes cnt %0d exp %0d cnt %0d", rx_q.size(), byte_count, exp_q.size(), exp_cnt); end
  endtask

  task automatic test_random();
    bit ok, r;
    int n, partial;
    for (int k = 0; k < 8; k++) begin
      r = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 3);
      tx_q.delete();
      for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
      partial = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
      run_frame(r, partial, 8'($urandom));
      ok = (rx_q.size() == exp_q.size());
      foreach (exp_q[i]) if (ok && rx_q[i] !== exp_q[i]) ok = 1'b0;
      n_tests++; if (!ok) begin n_fail++; $display("FAIL rand%0d_stream: got %0d bytes exp %0d", k, rx_q.size(), exp_q.size()); end
      n_tests++; if (ctrl_w0 !== exp_w0 || ctrl_w1 !== exp_w1 || strobes - s0 !== exp_strobes) begin
        n_fail++; $display("FAIL rand%0d_ctrl: got %h/%h/%0d exp %h/%h/%0d", k, ctrl_w0, ctrl_w1, strobes - s0, exp_w0, exp_w1, exp_strobes); end
      n_tests++; if (byte_count !== 8'(exp_cnt) || frame_err !== exp_err) begin
        n_fail++; $display("FAIL rand%0d_status: got cnt %0d err %b exp %0d %b", k, byte_count, frame_err, exp_cnt, exp_err); end
    end
  endtask

  initial begin
    test_reset();
    test_ctrl();
    test_overflow();
    test_partial();
    test_nreset();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
